// File: rtl/frame_pkg.sv
// Shared types and constants for the serial frame transmitter and receiver.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SIZE,
    DATA,
    CRC,
    STOP
  } frame_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         STUFF_RUN = 5;
  localparam logic       LINE_IDLE = 1'b0;
  localparam logic       START_BIT = 1'b1;
  localparam logic       STOP_BIT  = 1'b0;
  localparam int         FS_W      = 4;

endpackage

// File: rtl/frame_transmit_if.sv
// Data byte handshake between host and frame transmitter.
interface frame_transmit_if;

  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00), shared with the frame receiver.
module crc8_serial
  import frame_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       b,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ b;
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) crc_q <= CRC8_INIT;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/frame_transmit.sv
// Serial frame transmitter: start, size, data, CRC-8, stop.
// Define FRAME_STUFF_EN to insert a stuff bit after five equal line bits.
module frame_transmit
  import frame_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      baudrate,
  input  logic            start,
  input  logic [FS_W-1:0] framesize,
  frame_transmit_if.slave din_if,
  output logic            tx,
  output logic            busy,
  output logic            done,
  output logic            ur
);

  frame_state_t    state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      baud_q, baud_d;
  logic [FS_W-1:0] fs_q, fs_d;
  logic [FS_W-1:0] byte_q, byte_d;
  logic [FS_W-1:0] acc_q, acc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sreg_q, sreg_d;
  logic [7:0]      hold_q, hold_d;
  logic            full_q, full_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            ur_q, ur_d;
  logic            wrap, xfer, stuff;
  logic            shift_go, byte_go, crc_go;
  logic            crc_clr, crc_en, crc_b;
  logic [7:0]      crc;

  assign busy = state_q != IDLE;
  assign din_if.din_ready = busy && !full_q && (acc_q < fs_q);
  assign xfer = din_if.din_valid && din_if.din_ready;
  assign wrap = cnt_q == baud_q - 8'd1;

  crc8_serial u_crc (
    .clk   (clk),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .b     (crc_b),
    .crc   (crc)
  );

`ifdef FRAME_STUFF_EN
  logic [2:0] run_q, run_d;
  logic       in_reg;

  assign in_reg = state_q inside {SIZE, DATA, CRC};
  assign stuff  = in_reg && run_q == 3'(STUFF_RUN);

  // Run length of equal line bits inside the stuffed region.
  always_comb begin
    run_d = run_q;
    if (busy && wrap) begin
      if (stuff)
        run_d = 3'd1;
      else if (in_reg && tx_d == tx_q)
        run_d = run_q + 3'd1;
      else
        run_d = 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end
`else
  assign stuff = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    baud_d   = baud_q;
    fs_d     = fs_q;
    byte_d   = byte_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    sreg_d   = sreg_q;
    hold_d   = hold_q;
    full_d   = full_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    ur_d     = ur_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_b    = 1'b0;
    shift_go = 1'b0;
    byte_go  = 1'b0;
    crc_go   = 1'b0;

    if (xfer) begin
      hold_d = din_if.din;
      full_d = 1'b1;
      acc_d  = acc_q + 1'b1;
    end
    if (busy) cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;

    unique case (1'b1)
      !busy && start: begin
        state_d = START;
        cnt_d   = 8'd0;
        baud_d  = (baudrate == 8'd0) ? 8'd1 : baudrate;
        fs_d    = framesize;
        byte_d  = '0;
        acc_d   = '0;
        bit_d   = '0;
        full_d  = 1'b0;
        tx_d    = START_BIT;
        ur_d    = 1'b0;
        crc_clr = 1'b1;
      end
      busy && wrap && stuff: tx_d = ~tx_q;
      busy && wrap && !stuff: begin
        unique case (state_q)
          START: begin
            state_d = SIZE;
            bit_d   = '0;
            tx_d    = fs_q[FS_W-1];
            sreg_d  = {fs_q[FS_W-2:0], {(9-FS_W){1'b0}}};
            crc_en  = 1'b1;
            crc_b   = fs_q[FS_W-1];
          end
          SIZE: begin
            if (bit_q != 3'(FS_W-1)) shift_go = 1'b1;
            else if (fs_q == '0)     crc_go = 1'b1;
            else                     byte_go = 1'b1;
          end
          DATA: begin
            if (bit_q != 3'd7)        shift_go = 1'b1;
            else if (byte_q == fs_q)  crc_go = 1'b1;
            else                      byte_go = 1'b1;
          end
          CRC: begin
            if (bit_q != 3'd7) begin
              shift_go = 1'b1;
            end else begin
              state_d = STOP;
              tx_d    = STOP_BIT;
            end
          end
          STOP: begin
            state_d = IDLE;
            tx_d    = LINE_IDLE;
            done_d  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (shift_go) begin
      bit_d  = bit_q + 3'd1;
      tx_d   = sreg_q[7];
      sreg_d = {sreg_q[6:0], 1'b0};
      crc_en = state_q != CRC;
      crc_b  = sreg_q[7];
    end
    if (crc_go) begin
      state_d = CRC;
      bit_d   = '0;
      tx_d    = crc[7];
      sreg_d  = {crc[6:0], 1'b0};
    end
    // An empty buffer at a byte boundary aborts the frame.
    if (byte_go) begin
      if (full_q) begin
        state_d = DATA;
        bit_d   = '0;
        byte_d  = byte_q + 1'b1;
        tx_d    = hold_q[7];
        sreg_d  = {hold_q[6:0], 1'b0};
        full_d  = 1'b0;
        crc_en  = 1'b1;
        crc_b   = hold_q[7];
      end else begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        ur_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      baud_q  <= 8'd1;
      fs_q    <= '0;
      byte_q  <= '0;
      acc_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= LINE_IDLE;
      done_q  <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      fs_q    <= fs_d;
      byte_q  <= byte_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ur_q    <= ur_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign ur   = ur_q;

endmodule
